// File: rtl/imem_sync_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_sync_if
// Brief   : Program-load and fetch bus between a CPU/loader and imem_sync.
// Revision: 1.0 - initial release
// ============================================================================
interface imem_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  prog_done;
    logic                  load_req;
    logic [15:0]           prog_count;
    logic                  running;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  fetch_ready;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_fill;
    logic                  instr_ack;

    modport master (
        output prog_we, prog_addr, prog_data, prog_done, load_req,
        output fetch_req, fetch_pc, instr_ack,
        input  prog_count, running, fetch_ready, instr_valid, instr, instr_fill
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_done, load_req,
        input  fetch_req, fetch_pc, instr_ack,
        output prog_count, running, fetch_ready, instr_valid, instr, instr_fill
    );
endinterface
`default_nettype wire

// File: rtl/imem_sync.sv
`default_nettype none
// ============================================================================
// Module  : imem_sync
// Brief   : Loadable RAM-backed instruction store with a one-deep registered
//           fetch pipeline and NOP fill for unwritten/out-of-range words.
// Revision: 1.0 - initial release
// ============================================================================
module imem_sync #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    imem_sync_if.slave bus
);

    localparam int                  c_IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [1:0]          c_ST_LOAD  = 2'd0;
    localparam logic [1:0]          c_ST_RUN   = 2'd1;
    localparam logic [1:0]          c_ST_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_mask;
    logic [15:0]           r_prog_count;
    logic                  r_instr_valid;
    logic                  r_instr_fill;
    logic [DATA_WIDTH-1:0] r_instr;

    logic                  w_running;
    logic                  w_fetch_ready;
    logic                  w_prog_in_range;
    logic                  w_prog_wr;
    logic [c_IDX_W-1:0]    w_prog_idx;
    logic                  w_fetch_in_range;
    logic                  w_fetch_acc;
    logic                  w_fetch_fill;
    logic [c_IDX_W-1:0]    w_fetch_idx;
    logic                  w_load_entry;

    // Range checks use the full address so high PC bits never alias into the store.
    assign w_prog_in_range  = {1'b0, bus.prog_addr} < c_DEPTH;
    assign w_prog_idx       = bus.prog_addr[c_IDX_W-1:0];
    assign w_prog_wr        = (r_state == c_ST_LOAD) && bus.prog_we && w_prog_in_range;

    assign w_fetch_in_range = {1'b0, bus.fetch_pc} < c_DEPTH;
    assign w_fetch_idx      = bus.fetch_pc[c_IDX_W-1:0];
    assign w_fetch_acc      = bus.fetch_req && w_fetch_ready;
    assign w_fetch_fill     = !w_fetch_in_range || !r_mask[w_fetch_idx];

    assign w_load_entry     = (r_state != c_ST_LOAD) && (w_state_nxt == c_ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LOAD: begin
                if (bus.prog_done) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (bus.load_req) begin
                    w_state_nxt = r_instr_valid ? c_ST_DRAIN : c_ST_LOAD;
                end
            end
            c_ST_DRAIN: begin
                // Also leave if the pending word was acked on the way into DRAIN.
                if (!r_instr_valid || bus.instr_ack) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            default: w_state_nxt = c_ST_LOAD;
        endcase
    end

    always_comb begin
        w_running     = (r_state == c_ST_RUN);
        w_fetch_ready = w_running && !bus.load_req && (!r_instr_valid || bus.instr_ack);
    end

    always_ff @(posedge clk) begin
        if (w_prog_wr) begin
            r_mem[w_prog_idx] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask       <= '0;
            r_prog_count <= '0;
        end else if (w_load_entry) begin
            r_mask       <= '0;
            r_prog_count <= '0;
        end else if (w_prog_wr) begin
            r_mask[w_prog_idx] <= 1'b1;
            if (r_prog_count != 16'hFFFF) begin
                r_prog_count <= r_prog_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_instr_fill  <= 1'b0;
            r_instr       <= NOP_WORD;
        end else if (w_fetch_acc) begin
            r_instr_valid <= 1'b1;
            r_instr_fill  <= w_fetch_fill;
            r_instr       <= w_fetch_fill ? NOP_WORD : r_mem[w_fetch_idx];
        end else if (bus.instr_ack) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign bus.prog_count  = r_prog_count;
    assign bus.running     = w_running;
    assign bus.fetch_ready = w_fetch_ready;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_fill  = r_instr_fill;

endmodule
`default_nettype wire

// File: tb/tb_imem_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_imem_sync
// Brief   : Randomised scoreboard bench for imem_sync against a word-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_sync;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imem_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    imem_sync #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        fill;
        logic [31:0] word;
    } exp_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    int          m_count;
    bit          m_run;
    bit          chk_en = 1'b0;
    exp_t        q[$];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(logic [31:0] pc);
        exp_t e;
        if (pc >= 32'(DEPTH) || !m_wr[pc[5:0]]) begin
            e.fill = 1'b1;
            e.word = NOP;
        end else begin
            e.fill = 1'b0;
            e.word = m_mem[pc[5:0]];
        end
        return e;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
        m_count = 0;
    endfunction

    // Scoreboard monitor: one-deep pipeline means the queue holds at most the pending word.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("instr_valid", 64'(bus.instr_valid), 64'(q.size() != 0));
            check("fetch_ready", 64'(bus.fetch_ready),
                  64'(m_run && !bus.load_req && (q.size() == 0 || bus.instr_ack)));
            if (bus.instr_valid && bus.instr_ack) begin
                check("pending_depth", 64'(q.size()), 64'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("instr", 64'(bus.instr), 64'(e.word));
                    check("instr_fill", 64'(bus.instr_fill), 64'(e.fill));
                end
            end
            if (bus.fetch_req && bus.fetch_ready) q.push_back(model_fetch(bus.fetch_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_fetch_ready"}, 64'(bus.fetch_ready), 64'd0);
        check({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
        check({tag, "_instr"},       64'(bus.instr),       64'(NOP));
        check({tag, "_instr_fill"},  64'(bus.instr_fill),  64'd0);
        check({tag, "_running"},     64'(bus.running),     64'd0);
        check({tag, "_prog_count"},  64'(bus.prog_count),  64'd0);
    endtask

    task automatic apply_reset(string tag);
        chk_en        = 1'b0;
        rst_n         = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_done = 1'b0;
        bus.load_req  = 1'b0;
        bus.fetch_req = 1'b0;
        bus.instr_ack = 1'b0;
        #1;
        check_reset_outputs(tag);
        q.delete();
        model_clear();
        m_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
    endtask

    task automatic model_write(logic [31:0] a, logic [31:0] d);
        if (a < 32'(DEPTH)) begin
            m_mem[a[5:0]] = d;
            m_wr[a[5:0]]  = 1'b1;
            if (m_count < 'hFFFF) m_count++;
        end
    endtask

    task automatic load_word(logic [31:0] a, logic [31:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        bus.prog_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic finish_load(bit with_wr, logic [31:0] a, logic [31:0] d);
        bus.prog_we   = with_wr;
        bus.prog_addr = a;
        bus.prog_data = d;
        bus.prog_done = 1'b1;
        tick();
        bus.prog_we   = 1'b0;
        bus.prog_done = 1'b0;
        if (with_wr) model_write(a, d);
        m_run = 1'b1;
        check("running_after_done", 64'(bus.running), 64'd1);
        check("ready_after_done", 64'(bus.fetch_ready), 64'd1);
        check("count_after_done", 64'(bus.prog_count), 64'(m_count));
    endtask

    task automatic idle(int n);
        bus.fetch_req = 1'b0;
        bus.instr_ack = 1'b1;
        repeat (n) tick();
    endtask

    task automatic fetch_one(logic [31:0] pc);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        bus.instr_ack = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic enter_load_from_run(string tag);
        bus.load_req = 1'b1;
        #1;
        check({tag, "_ready_forced_low"}, 64'(bus.fetch_ready), 64'd0);
        tick();
        bus.load_req = 1'b0;
        m_run = 1'b0;
        model_clear();
        check({tag, "_running"}, 64'(bus.running), 64'd0);
        check({tag, "_count_cleared"}, 64'(bus.prog_count), 64'd0);
    endtask

    task automatic random_run(int n);
        for (int i = 0; i < n; i++) begin
            bus.fetch_req = ($urandom_range(0, 3) != 0);
            bus.instr_ack = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       bus.fetch_pc = 32'($urandom_range(32, DEPTH + 8));
                1:       bus.fetch_pc = 32'h0000_FFFF;
                2:       bus.fetch_pc = $urandom;
                3:       bus.fetch_pc = 32'h8000_0000 | 32'($urandom_range(0, 31));
                default: bus.fetch_pc = 32'($urandom_range(0, 31));
            endcase
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_done = 1'b0;
        bus.load_req  = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.instr_ack = 1'b0;
        #1;
        apply_reset("reset");

        // Program image 0..31 plus dropped out-of-range writes.
        for (int i = 0; i < 32; i++) load_word(32'(i), $urandom);
        load_word(32'h0000_0040, 32'hBAD0_0001);
        load_word(32'hFFFF_FFFF, 32'hBAD0_0002);
        check("count_after_image", 64'(bus.prog_count), 64'd32);
        check("running_in_load", 64'(bus.running), 64'd0);
        check("ready_in_load", 64'(bus.fetch_ready), 64'd0);
        finish_load(1'b0, '0, '0);

        // Back-to-back fetch with ack held high: monitor demands ready every cycle.
        for (int i = 0; i < 32; i++) begin
            bus.fetch_req = 1'b1;
            bus.fetch_pc  = 32'(i);
            bus.instr_ack = 1'b1;
            tick();
        end
        idle(2);

        fetch_one(32'd40);
        fetch_one(32'h0000_FFFF);
        fetch_one(32'h8000_0005);

        // Backpressure on pc=3.
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'd3;
        bus.instr_ack = 1'b0;
        tick();
        e = model_fetch(32'd3);
        bus.fetch_pc = 32'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid_held", 64'(bus.instr_valid), 64'd1);
            check("bp_ready_low", 64'(bus.fetch_ready), 64'd0);
            check("bp_instr_stable", 64'(bus.instr), 64'(e.word));
        end
        bus.instr_ack = 1'b1;
        #1;
        check("bp_ready_on_ack", 64'(bus.fetch_ready), 64'd1);
        tick();
        idle(2);

        random_run(200);
        idle(2);

        // load_req with a word pending: DRAIN until ack.
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'd7;
        bus.instr_ack = 1'b0;
        tick();
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b1;
        #1;
        check("drain_ready_forced_low", 64'(bus.fetch_ready), 64'd0);
        repeat (3) begin
            tick();
            check("drain_running", 64'(bus.running), 64'd0);
            check("drain_valid_held", 64'(bus.instr_valid), 64'd1);
        end
        bus.instr_ack = 1'b1;
        tick();
        bus.load_req = 1'b0;
        m_run = 1'b0;
        model_clear();
        check("drain_exit_valid", 64'(bus.instr_valid), 64'd0);
        check("drain_exit_count", 64'(bus.prog_count), 64'd0);
        check("drain_exit_running", 64'(bus.running), 64'd0);

        // Mask was cleared: earlier program reads as fill.
        finish_load(1'b0, '0, '0);
        fetch_one(32'd5);
        idle(1);
        enter_load_from_run("relaod");

        // Overwrite counts; same-cycle write and done.
        load_word(32'd5, 32'h1111_1111);
        check("count_one", 64'(bus.prog_count), 64'd1);
        finish_load(1'b1, 32'd5, 32'hDEAD_BEEF);
        fetch_one(32'd5);
        fetch_one(32'd6);
        random_run(40);

        // Asynchronous reset mid-stream, away from any edge.
        #1;
        apply_reset("midreset");
        load_word(32'h0000_0040, 32'h1234_5678);
        check("count_drop_oor", 64'(bus.prog_count), 64'd0);
        finish_load(1'b0, '0, '0);
        fetch_one(32'd5);
        idle(2);

        chk_en = 1'b0;
        check("queue_empty_at_end", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
